// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared constants and state type for the trap controller
//
// Purpose: CSR addresses, exception cause codes and the trap FSM state type.
// Ports:   none (package).

package trap_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  localparam int CAUSE_LOAD_MISALIGNED  = 4;
  localparam int CAUSE_STORE_MISALIGNED = 6;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    REDIRECT,
    HANDLER,
    RETURN
  } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// rtl/trap_csr_file.sv - mtvec/mepc/mcause/mtval registers with capture priority
//
// Purpose: holds the machine trap CSRs, applies write masking, gives hardware
//          capture priority over software writes, and provides a comb read mux.
// Ports:
//   clk, reset              clock, async active-high reset
//   csr_we/addr/wdata       software CSR write port
//   capture                 exception accepted this cycle
//   cap_pc/cap_cause/cap_tval  values captured into mepc/mcause/mtval
//   csr_rdata               comb read of csr_addr (unmapped -> 0)
//   mtvec_next              mtvec including a same-cycle write
//   mepc                    current mepc

module trap_csr_file
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            capture,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [XLEN-1:0] cap_cause,
  input  logic [XLEN-1:0] cap_tval,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] mtvec_next,
  output logic [XLEN-1:0] mepc
);

  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [XLEN-1:0] wdata_aligned;

  assign wdata_aligned = {csr_wdata[XLEN-1:2], 2'b00};

  // The FSM samples this when building the trap redirect, so a write landing
  // in the final drain cycle is still honoured by that same trap.
  assign mtvec_next = (csr_we && csr_addr == CSR_MTVEC) ? wdata_aligned : mtvec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtvec  <= MTVEC_RESET;
      mepc   <= '0;
      mcause <= '0;
      mtval  <= '0;
    end else begin
      mtvec <= mtvec_next;
      // An accepted exception overrides any software write to the capture CSRs.
      if (capture) begin
        mepc   <= cap_pc;
        mcause <= cap_cause;
        mtval  <= cap_tval;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MEPC:   mepc   <= wdata_aligned;
          CSR_MCAUSE: mcause <= csr_wdata;
          CSR_MTVAL:  mtval  <= csr_wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MTVEC:  csr_rdata = mtvec;
      CSR_MEPC:   csr_rdata = mepc;
      CSR_MCAUSE: csr_rdata = mcause;
      CSR_MTVAL:  csr_rdata = mtval;
      default:    csr_rdata = '0;
    endcase
  end

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - exception responder: capture, drain, redirect, mret
//
// Purpose: accepts an exception request, captures mepc/mcause/mtval, flushes
//          the pipeline until drained, redirects fetch to mtvec, and returns
//          to mepc on mret.
// Ports:
//   clk, reset                      clock, async active-high reset
//   exc_valid/cause/pc/tval         exception request (held until accepted)
//   exc_ready                       comb, high only in IDLE
//   mret_valid                      mret retired pulse
//   pipe_empty                      pipeline has no valid instructions
//   flush, redirect_valid, redirect_pc, in_trap   registered control outputs
//   csr_we/addr/wdata, csr_rdata    CSR access port

module trap_controller
  import trap_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = 32'h0000_0100,
  parameter int              DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  output logic            exc_ready,
  input  logic            mret_valid,
  input  logic            pipe_empty,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            in_trap,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  // The first flush cycle is the one right after accept, so the counter
  // starts one short of the full drain length.
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  trap_state_e     state;
  logic [CW-1:0]   cnt;
  logic            capture;
  logic [XLEN-1:0] mtvec_next;
  logic [XLEN-1:0] mepc;

  assign exc_ready = (state == IDLE);
  assign capture   = exc_valid & exc_ready;

  trap_csr_file #(
    .XLEN        (XLEN),
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr (
    .clk        (clk),
    .reset      (reset),
    .csr_we     (csr_we),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .capture    (capture),
    .cap_pc     (exc_pc),
    .cap_cause  (exc_cause),
    .cap_tval   (exc_tval),
    .csr_rdata  (csr_rdata),
    .mtvec_next (mtvec_next),
    .mepc       (mepc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      in_trap        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // mret outside a handler is meaningless; an exception always wins.
          if (exc_valid) begin
            state <= DRAIN;
            cnt   <= DRAIN_LOAD;
            flush <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (pipe_empty) begin
            state          <= REDIRECT;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= {mtvec_next[XLEN-1:2], 2'b00};
          end
        end
        REDIRECT: begin
          redirect_valid <= 1'b0;
          in_trap        <= 1'b1;
          state          <= HANDLER;
        end
        HANDLER: begin
          if (mret_valid) begin
            state          <= RETURN;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc;
            in_trap        <= 1'b0;
          end
        end
        RETURN: begin
          flush          <= 1'b0;
          redirect_valid <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          state          <= IDLE;
          flush          <= 1'b0;
          redirect_valid <= 1'b0;
          in_trap        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - directed self-checking bench for trap_controller

module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        exc_ready;
  logic        mret_valid;
  logic        pipe_empty;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        in_trap;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk            (clk),
    .reset          (reset),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .exc_ready      (exc_ready),
    .mret_valid     (mret_valid),
    .pipe_empty     (pipe_empty),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .in_trap        (in_trap),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic raise_exc(input logic [31:0] c, input logic [31:0] pc, input logic [31:0] tv);
    exc_valid = 1'b1;
    exc_cause = c;
    exc_pc    = pc;
    exc_tval  = tv;
    #1;
  endtask

  // From HANDLER: mret pulse, RETURN cycle, back in IDLE.
  task automatic do_mret();
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0;
    mret_valid = 0; pipe_empty = 1; csr_we = 0; csr_addr = 0; csr_wdata = 0;
    step(); step();
    reset = 1'b0;
    step();
    n_cmp++; if ({flush, redirect_valid, in_trap} !== 3'b000) begin
      $display("FAIL reset_outs: got %b want 000", {flush, redirect_valid, in_trap}); n_err++; end
    n_cmp++; if (redirect_pc !== 32'h0) begin
      $display("FAIL reset_rpc: got %h want 0", redirect_pc); n_err++; end
    n_cmp++; if (exc_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b want 1", exc_ready); n_err++; end
    read_csr(12'h305, d);
    n_cmp++; if (d !== 32'h100) begin
      $display("FAIL reset_mtvec: got %h want 100", d); n_err++; end
    read_csr(12'h341, d);
    n_cmp++; if (d !== 32'h0) begin
      $display("FAIL reset_mepc: got %h want 0", d); n_err++; end
  endtask

  task automatic test_trap_entry();
    logic [31:0] d;
    raise_exc(32'd4, 32'h40, 32'h1002);
    n_cmp++; if (exc_ready !== 1'b1) begin
      $display("FAIL t1_ready: got %b want 1", exc_ready); n_err++; end
    step();
    exc_valid = 1'b0;
    n_cmp++; if ({flush, redirect_valid} !== 2'b10) begin
      $display("FAIL t1_flush1: got %b want 10", {flush, redirect_valid}); n_err++; end
    step();
    n_cmp++; if ({flush, redirect_valid} !== 2'b10) begin
      $display("FAIL t1_flush2: got %b want 10", {flush, redirect_valid}); n_err++; end
    step();
    n_cmp++; if ({flush, redirect_valid} !== 2'b01 || redirect_pc !== 32'h100) begin
      $display("FAIL t1_redirect: got fr=%b pc=%h want 01 pc=100", {flush, redirect_valid}, redirect_pc); n_err++; end
    step();
    n_cmp++; if ({redirect_valid, in_trap, exc_ready} !== 3'b010) begin
      $display("FAIL t1_handler: got %b want 010", {redirect_valid, in_trap, exc_ready}); n_err++; end
    read_csr(12'h341, d);
    n_cmp++; if (d !== 32'h40) begin
      $display("FAIL t1_mepc: got %h want 40", d); n_err++; end
    read_csr(12'h342, d);
    n_cmp++; if (d !== 32'd4) begin
      $display("FAIL t1_mcause: got %h want 4", d); n_err++; end
    read_csr(12'h343, d);
    n_cmp++; if (d !== 32'h1002) begin
      $display("FAIL t1_mtval: got %h want 1002", d); n_err++; end
  endtask

  task automatic test_mret();
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    n_cmp++; if ({flush, redirect_valid, in_trap} !== 3'b110 || redirect_pc !== 32'h40) begin
      $display("FAIL t2_return: got fri=%b pc=%h want 110 pc=40", {flush, redirect_valid, in_trap}, redirect_pc); n_err++; end
    step();
    n_cmp++; if ({flush, redirect_valid, exc_ready} !== 3'b001) begin
      $display("FAIL t2_idle: got %b want 001", {flush, redirect_valid, exc_ready}); n_err++; end
  endtask

  task automatic test_drain_stall();
    pipe_empty = 1'b0;
    raise_exc(32'd6, 32'h60, 32'h2001);
    step();
    exc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({flush, redirect_valid} !== 2'b10) begin
        $display("FAIL t3_stall%0d: got %b want 10", i, {flush, redirect_valid}); n_err++; end
      step();
    end
    n_cmp++; if ({flush, redirect_valid} !== 2'b10) begin
      $display("FAIL t3_stall_end: got %b want 10", {flush, redirect_valid}); n_err++; end
    pipe_empty = 1'b1;
    step();
    n_cmp++; if ({flush, redirect_valid} !== 2'b01 || redirect_pc !== 32'h100) begin
      $display("FAIL t3_redirect: got fr=%b pc=%h want 01 pc=100", {flush, redirect_valid}, redirect_pc); n_err++; end
    step();
    do_mret();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    raise_exc(32'd6, 32'h80, 32'h2003);
    mret_valid = 1'b1;
    #1;
    n_cmp++; if (exc_ready !== 1'b1) begin
      $display("FAIL t4_ready: got %b want 1", exc_ready); n_err++; end
    step();
    exc_valid = 1'b0; mret_valid = 1'b0;
    n_cmp++; if (flush !== 1'b1) begin
      $display("FAIL t4_exc_wins: got flush=%b want 1", flush); n_err++; end
    step(); step(); step();
    raise_exc(32'd4, 32'h90, 32'h3001);
    n_cmp++; if ({in_trap, exc_ready} !== 2'b10) begin
      $display("FAIL t4_nested_ready: got %b want 10", {in_trap, exc_ready}); n_err++; end
    step(); step();
    read_csr(12'h341, d);
    n_cmp++; if (d !== 32'h80) begin
      $display("FAIL t4_mepc_held: got %h want 80", d); n_err++; end
    mret_valid = 1'b1;
    step();
    mret_valid = 1'b0;
    n_cmp++; if (exc_ready !== 1'b0 || redirect_pc !== 32'h80) begin
      $display("FAIL t4_return: got rdy=%b pc=%h want 0 pc=80", exc_ready, redirect_pc); n_err++; end
    step();
    n_cmp++; if (exc_ready !== 1'b1) begin
      $display("FAIL t4_ready_again: got %b want 1", exc_ready); n_err++; end
    step();
    exc_valid = 1'b0;
    read_csr(12'h341, d);
    n_cmp++; if (d !== 32'h90) begin
      $display("FAIL t4_second_mepc: got %h want 90", d); n_err++; end
    step(); step(); step();
    do_mret();
  endtask

  task automatic test_csr();
    logic [31:0] d;
    csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h203;
    step();
    csr_we = 1'b0;
    read_csr(12'h305, d);
    n_cmp++; if (d !== 32'h200) begin
      $display("FAIL t5_mtvec_mask: got %h want 200", d); n_err++; end
    raise_exc(32'd4, 32'hA0, 32'h4001);
    csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h55;
    step();
    csr_we = 1'b0; exc_valid = 1'b0;
    read_csr(12'h341, d);
    n_cmp++; if (d !== 32'hA0) begin
      $display("FAIL t5_capture_prio: got %h want a0", d); n_err++; end
    step(); step();
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
      $display("FAIL t5_redirect_new: got v=%b pc=%h want 1 pc=200", redirect_valid, redirect_pc); n_err++; end
    step();
    do_mret();
    // mtvec written in the final drain cycle must steer this trap's redirect.
    raise_exc(32'd6, 32'hB0, 32'h5001);
    step();
    exc_valid = 1'b0;
    step();
    csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h30E;
    step();
    csr_we = 1'b0;
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h30C) begin
      $display("FAIL t5_redirect_drain_wr: got v=%b pc=%h want 1 pc=30c", redirect_valid, redirect_pc); n_err++; end
    step();
    do_mret();
    read_csr(12'h7C0, d);
    n_cmp++; if (d !== 32'h0) begin
      $display("FAIL t5_unmapped: got %h want 0", d); n_err++; end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    raise_exc(32'd4, 32'hC0, 32'h6001);
    step();
    exc_valid = 1'b0;
    n_cmp++; if (flush !== 1'b1) begin
      $display("FAIL t6_pre: got flush=%b want 1", flush); n_err++; end
    reset = 1'b1;
    #1;
    n_cmp++; if ({flush, redirect_valid, in_trap} !== 3'b000) begin
      $display("FAIL t6_async: got %b want 000", {flush, redirect_valid, in_trap}); n_err++; end
    read_csr(12'h305, d);
    n_cmp++; if (d !== 32'h100) begin
      $display("FAIL t6_mtvec: got %h want 100", d); n_err++; end
    read_csr(12'h341, d);
    n_cmp++; if (d !== 32'h0) begin
      $display("FAIL t6_mepc: got %h want 0", d); n_err++; end
    step();
    reset = 1'b0;
    step(); step(); step();
    n_cmp++; if ({flush, redirect_valid, exc_ready} !== 3'b001) begin
      $display("FAIL t6_no_pending: got %b want 001", {flush, redirect_valid, exc_ready}); n_err++; end
  endtask

  initial begin
    test_reset();
    test_trap_entry();
    test_mret();
    test_drain_stall();
    test_back_to_back();
    test_csr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
